// File: rtl/decompose_mem_ctrl.sv
// Read/write memory sequencer for the ML-DSA decompose unit: streams source rows into the
// datapath under an inflight credit limit and writes r0 results (sign) or streams w1 only (verify).
module decompose_mem_ctrl #(
  parameter int ADDR_W        = 15,
  parameter int ROWS_PER_POLY = 64,
  parameter int MAX_POLY      = 8,
  parameter int MAX_INFLIGHT  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          zeroize,
  input  logic                          start_i,
  input  logic                          mode_i,
  input  logic [$clog2(MAX_POLY+1)-1:0] num_poly_i,
  input  logic [ADDR_W-1:0]             src_base_i,
  input  logic [ADDR_W-1:0]             dst_base_i,
  input  logic                          w1_ready_i,
  input  logic                          dp_valid_i,
  output logic                          mem_rd_en_o,
  output logic [ADDR_W-1:0]             mem_rd_addr_o,
  output logic                          mem_wr_en_o,
  output logic [ADDR_W-1:0]             mem_wr_addr_o,
  output logic                          w1_valid_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int NP_W  = $clog2(MAX_POLY + 1);
  localparam int CNT_W = $clog2(MAX_POLY * ROWS_PER_POLY + 1);
  localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {RD_IDLE, RD_MEM, RD_DONE} rd_state_t;
  typedef enum logic {WR_IDLE, WR_MEM} wr_state_t;

  rd_state_t         rd_state_reg, rd_state_next;
  wr_state_t         wr_state_reg, wr_state_next;
  logic              mode_reg;
  logic [ADDR_W-1:0] src_reg, dst_reg;
  logic [CNT_W-1:0]  total_reg, rd_cnt_reg, wr_cnt_reg;
  logic [IF_W-1:0]   inflight_reg;
  logic              done_reg;

  logic [NP_W-1:0]   num_poly_clamped;
  logic [CNT_W-1:0]  total_start;
  logic              busy, start_acc, start_go, start_empty;
  logic              rd_issue, wr_fire, rd_last, wr_last;

  assign num_poly_clamped = (num_poly_i > NP_W'(MAX_POLY)) ? NP_W'(MAX_POLY) : num_poly_i;
  assign total_start      = CNT_W'(num_poly_clamped) * CNT_W'(ROWS_PER_POLY);

  assign busy        = (rd_state_reg != RD_IDLE) || (wr_state_reg != WR_IDLE);
  assign start_acc   = start_i && !busy && !zeroize;
  assign start_go    = start_acc && (total_start != '0);
  assign start_empty = start_acc && (total_start == '0);

  // zeroize gates the strobes in its own cycle so nothing leaks out while clearing
  assign rd_issue = (rd_state_reg == RD_MEM) && (inflight_reg < IF_W'(MAX_INFLIGHT))
                    && w1_ready_i && !zeroize;
  assign wr_fire  = (wr_state_reg == WR_MEM) && dp_valid_i && !zeroize;
  assign rd_last  = rd_issue && (rd_cnt_reg == total_reg - CNT_W'(1));
  assign wr_last  = wr_fire && (wr_cnt_reg == total_reg - CNT_W'(1));

  always_comb begin
    rd_state_next = rd_state_reg;
    wr_state_next = wr_state_reg;
    case (rd_state_reg)
      RD_IDLE: if (start_go) rd_state_next = RD_MEM;
      // A write side that finishes early (spurious dp_valid) must not strand the read side
      RD_MEM:  if (wr_last) rd_state_next = RD_IDLE;
               else if (rd_last) rd_state_next = RD_DONE;
      RD_DONE: if (wr_last || wr_state_reg == WR_IDLE) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
    case (wr_state_reg)
      WR_IDLE: if (start_go) wr_state_next = WR_MEM;
      WR_MEM:  if (wr_last) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg <= RD_IDLE;
      wr_state_reg <= WR_IDLE;
    end else if (zeroize) begin
      rd_state_reg <= RD_IDLE;
      wr_state_reg <= WR_IDLE;
    end else begin
      rd_state_reg <= rd_state_next;
      wr_state_reg <= wr_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg     <= 1'b0;
      src_reg      <= '0;
      dst_reg      <= '0;
      total_reg    <= '0;
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
      inflight_reg <= '0;
      done_reg     <= 1'b0;
    end else if (zeroize) begin
      mode_reg     <= 1'b0;
      src_reg      <= '0;
      dst_reg      <= '0;
      total_reg    <= '0;
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
      inflight_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= wr_last || start_empty;
      if (start_go) begin
        mode_reg     <= mode_i;
        src_reg      <= src_base_i;
        dst_reg      <= dst_base_i;
        total_reg    <= total_start;
        rd_cnt_reg   <= '0;
        wr_cnt_reg   <= '0;
        inflight_reg <= '0;
      end else begin
        if (rd_issue) rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
        if (wr_fire)  wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
        if (rd_issue && !(wr_fire && inflight_reg != '0))
          inflight_reg <= inflight_reg + IF_W'(1);
        else if (!rd_issue && wr_fire && inflight_reg != '0)
          inflight_reg <= inflight_reg - IF_W'(1);
      end
    end
  end

  assign mem_rd_en_o   = rd_issue;
  assign mem_rd_addr_o = rd_issue ? (src_reg + ADDR_W'(rd_cnt_reg)) : '0;
  assign mem_wr_en_o   = wr_fire && !mode_reg;
  assign mem_wr_addr_o = mem_wr_en_o ? (dst_reg + ADDR_W'(wr_cnt_reg)) : '0;
  assign w1_valid_o    = wr_fire;
  assign busy_o        = busy;
  assign done_o        = done_reg;

endmodule

// File: tb/tb_decompose_mem_ctrl.sv
// Directed bench for decompose_mem_ctrl: a fixed-latency datapath echo plus a negedge
// monitor feeding immediate-assertion checks.
module tb_decompose_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        zeroize = 1'b0;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [3:0]  num_poly_i = '0;
  logic [14:0] src_base_i = '0;
  logic [14:0] dst_base_i = '0;
  logic        w1_ready_i = 1'b1;
  logic        dp_valid_i = 1'b0;
  logic        mem_rd_en_o, mem_wr_en_o, w1_valid_o, busy_o, done_o;
  logic [14:0] mem_rd_addr_o, mem_wr_addr_o;

  decompose_mem_ctrl dut (
    .clk(clk), .rst(rst), .zeroize(zeroize), .start_i(start_i), .mode_i(mode_i),
    .num_poly_i(num_poly_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i),
    .w1_ready_i(w1_ready_i), .dp_valid_i(dp_valid_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_wr_en_o(mem_wr_en_o), .mem_wr_addr_o(mem_wr_addr_o),
    .w1_valid_o(w1_valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int q[$];
  bit echo_en = 1'b1;
  bit gap = 1'b0;
  int rd_count, wr_count, w1_count, done_count, rd_in_gap, max_out;
  int last_wr_cyc, last_w1_cyc, done_cyc, rd_base, wr_base;
  logic busy_at_done;
  int rd_log[0:511];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Datapath model: each read returns dp_valid 3 cycles later; held rows release one per cycle
  always @(posedge clk) begin
    cyc++;
    #1;
    if (echo_en && q.size() > 0 && q[0] <= cyc) begin
      dp_valid_i = 1'b1;
      void'(q.pop_front());
    end else begin
      dp_valid_i = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mem_rd_en_o) begin
      chk("rd_addr", 32'(mem_rd_addr_o), (rd_base + rd_count) & 32'h7fff);
      if (rd_count < 512) rd_log[rd_count] = int'(mem_rd_addr_o);
      rd_count++;
      if (gap) rd_in_gap++;
      q.push_back(cyc + 3);
    end
    if (mem_wr_en_o) begin
      chk("wr_addr", 32'(mem_wr_addr_o), (wr_base + wr_count) & 32'h7fff);
      wr_count++;
      last_wr_cyc = cyc;
    end
    if (w1_valid_o) begin
      w1_count++;
      last_w1_cyc = cyc;
    end
    if (done_o) begin
      done_count++;
      done_cyc = cyc;
      busy_at_done = busy_o;
    end
    if (rd_count - w1_count > max_out) max_out = rd_count - w1_count;
  end

  task automatic clear_stats(input int src, input int dst);
    rd_count = 0; wr_count = 0; w1_count = 0; done_count = 0; rd_in_gap = 0; max_out = 0;
    last_wr_cyc = -1; last_w1_cyc = -1; done_cyc = -1; busy_at_done = 1'bx;
    rd_base = src; wr_base = dst;
  endtask

  task automatic start_op(input bit m, input int np, input int src, input int dst);
    clear_stats(src, dst);
    mode_i = m; num_poly_i = 4'(np); src_base_i = 15'(src); dst_base_i = 15'(dst);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_count == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_count != 0), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rows(input int rows, input int budget);
    int n = 0;
    while (rd_count < rows && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rows_reached", 32'(rd_count >= rows), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int snap_wr, snap_w1;
    clear_stats(0, 0);
    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_en", 32'(mem_rd_en_o), 0);
    chk("rst_wr_en", 32'(mem_wr_en_o), 0);
    chk("rst_w1", 32'(w1_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    @(posedge clk); #1;

    // Sign, one polynomial
    start_op(1'b0, 1, 'h100, 'h200);
    @(negedge clk);
    chk("s1_busy", 32'(busy_o), 1);
    wait_done(400);
    chk("s1_reads", rd_count, 64);
    chk("s1_writes", wr_count, 64);
    chk("s1_w1", w1_count, 64);
    chk("s1_last_rd", rd_log[63], 'h13f);
    chk("s1_done_lat", done_cyc, last_wr_cyc + 1);
    chk("s1_busy_at_done", 32'(busy_at_done), 0);
    repeat (5) @(posedge clk); #1;
    chk("s1_done_once", done_count, 1);

    // Verify, eight polynomials, datapath held back
    echo_en = 1'b0;
    start_op(1'b1, 8, 'h1000, 'h3000);
    repeat (20) @(posedge clk); #1;
    chk("v_stall_reads", rd_count, 4);
    echo_en = 1'b1;
    wait_done(3000);
    chk("v_reads", rd_count, 512);
    chk("v_writes", wr_count, 0);
    chk("v_w1", w1_count, 512);
    chk("v_max_inflight", max_out, 4);
    chk("v_done_lat", done_cyc, last_w1_cyc + 1);

    // w1_ready gap mid-stream
    start_op(1'b0, 1, 'h400, 'h500);
    wait_rows(20, 100);
    w1_ready_i = 1'b0; gap = 1'b1;
    repeat (10) @(posedge clk); #1;
    w1_ready_i = 1'b1; gap = 1'b0;
    wait_done(400);
    chk("g_reads_in_gap", rd_in_gap, 0);
    chk("g_reads", rd_count, 64);
    chk("g_writes", wr_count, 64);

    // Address wrap
    start_op(1'b0, 1, 'h7ff0, 'h10);
    wait_done(400);
    chk("wrap_row15", rd_log[15], 'h7fff);
    chk("wrap_row16", rd_log[16], 'h0000);
    chk("wrap_reads", rd_count, 64);

    // Zero polynomials
    start_op(1'b0, 0, 'h100, 'h200);
    @(negedge clk);
    chk("z_done", 32'(done_o), 1);
    chk("z_busy", 32'(busy_o), 0);
    repeat (5) @(posedge clk); #1;
    chk("z_reads", rd_count + wr_count + w1_count, 0);
    chk("z_done_once", done_count, 1);

    // Start while busy is ignored
    start_op(1'b0, 2, 'h2000, 'h2400);
    repeat (10) @(posedge clk); #1;
    mode_i = 1'b1; num_poly_i = 4'd1; src_base_i = 15'h6000; dst_base_i = 15'h6100;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(600);
    chk("b_reads", rd_count, 128);
    chk("b_writes", wr_count, 128);
    repeat (5) @(posedge clk); #1;
    chk("b_done_once", done_count, 1);

    // Count above MAX_POLY clamps to MAX_POLY
    start_op(1'b0, 9, 'h0, 'h4000);
    wait_done(1000);
    chk("c_reads", rd_count, 512);
    chk("c_writes", wr_count, 512);

    // Zeroize at row 30, then a clean run
    start_op(1'b0, 1, 'h100, 'h200);
    wait_rows(30, 100);
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    @(negedge clk);
    chk("zz_rd_en", 32'(mem_rd_en_o), 0);
    chk("zz_wr_en", 32'(mem_wr_en_o), 0);
    chk("zz_w1", 32'(w1_valid_o), 0);
    chk("zz_busy", 32'(busy_o), 0);
    chk("zz_done", 32'(done_o), 0);
    snap_wr = wr_count; snap_w1 = w1_count;
    repeat (10) @(posedge clk); #1;
    chk("zz_no_writes", wr_count, snap_wr);
    chk("zz_no_w1", w1_count, snap_w1);
    chk("zz_no_done", done_count, 0);
    start_op(1'b0, 1, 'h100, 'h200);
    wait_done(400);
    chk("zz_rerun_reads", rd_count, 64);
    chk("zz_rerun_writes", wr_count, 64);
    chk("zz_rerun_done_lat", done_cyc, last_wr_cyc + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
